npc_mem_arb: RTL and testbench

Single-port memory arbiter and load/store lane unit for the npc core. Accepts instruction-fetch and data requests over valid/ready handshakes, grants one at a time onto a shared fixed-latency memory port, generates byte strobes and lane-replicated write data, and returns lane-aligned read data. It replaces the core's separate fixed-mask read, write and fetch memory instances with one parametrised, multi-cycle port.

---
 rtl/npc_mem_arb_if.sv | 42 ++++
 rtl/npc_mem_arb.sv | 173 +++++++++++++++++
 tb/tb_npc_mem_arb.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_mem_arb_if.sv
// rtl/npc_mem_arb_if.sv - fetch/data request-response and memory-port bundle for npc_mem_arb
interface npc_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [1:0]        d_size;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_size, d_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata, d_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_size, d_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rdata, d_req_ready, d_rsp_valid, d_rdata, d_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/npc_mem_arb.sv
// rtl/npc_mem_arb.sv - fetch/data arbiter onto one fixed-latency memory port with lane handling
// Optional misaligned-access reporting: NPC_MEM_ARB_MISALIGN_CHK_EN
module npc_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  npc_mem_arb_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (LAT > 2) ? $clog2(LAT - 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic              src_d_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        d_size_eff;
  logic              d_hs, if_hs, hs_err;
  logic [OFF_W-1:0]  off;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] wrep, rd_mask, rd_shift, fetch_word;

  // Clearing the low sz bits both aligns legal accesses and truncates misaligned ones.
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
    logic [ADDR_W-1:0] m;
    m = '1;
    m = m << sz;
    return a & m;
  endfunction

  assign d_size_eff = (DATA_W == 32 && bus.d_size == 2'd3) ? 2'd2 : bus.d_size;

  assign bus.d_req_ready  = (state_q == IDLE) && !rst;
  assign bus.if_req_ready = (state_q == IDLE) && !rst && !bus.d_req_valid;
  assign d_hs  = bus.d_req_valid && bus.d_req_ready;
  assign if_hs = bus.if_req_valid && bus.if_req_ready;

`ifdef NPC_MEM_ARB_MISALIGN_CHK_EN
  logic d_mis, if_mis;
  assign d_mis  = (d_size_eff == 2'd1 && bus.d_addr[0]) ||
                  (d_size_eff == 2'd2 && |bus.d_addr[1:0]) ||
                  (d_size_eff == 2'd3 && |bus.d_addr[2:0]);
  assign if_mis = |bus.if_addr[1:0];
  assign hs_err = (d_hs && d_mis) || (if_hs && if_mis);
`else
  assign hs_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_d_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (d_hs) begin
        src_d_q <= 1'b1;
        addr_q  <= align(bus.d_addr, d_size_eff);
        we_q    <= bus.d_we;
        size_q  <= d_size_eff;
        wdata_q <= bus.d_wdata;
        err_q   <= hs_err;
      end else if (if_hs) begin
        src_d_q <= 1'b0;
        addr_q  <= align(bus.if_addr, 2'd2);
        we_q    <= 1'b0;
        size_q  <= 2'd2;
        wdata_q <= '0;
        err_q   <= hs_err;
      end
      if (state_q == ISSUE) cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign off      = addr_q[OFF_W-1:0];
  assign rd_shift = bus.mem_rdata >> {off, 3'b000};

  always_comb begin
    strb    = '1;
    wrep    = wdata_q;
    rd_mask = '1;
    case (size_q)
      2'd0: begin
        strb    = STRB_W'(1) << off;
        wrep    = {STRB_W{wdata_q[7:0]}};
        rd_mask = DATA_W'(8'hFF);
      end
      2'd1: begin
        strb    = STRB_W'(3) << off;
        wrep    = {(STRB_W / 2){wdata_q[15:0]}};
        rd_mask = DATA_W'(16'hFFFF);
      end
      2'd2: begin
        strb    = STRB_W'(4'hF) << off;
        wrep    = {(DATA_W / 32){wdata_q[31:0]}};
        rd_mask = DATA_W'(32'hFFFF_FFFF);
      end
      default: ;
    endcase
  end

  generate
    if (DATA_W == 64) begin : g_lane64
      assign fetch_word = {32'b0, addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]};
    end else begin : g_lane32
      assign fetch_word = bus.mem_rdata;
    end
  endgenerate

  always_comb begin
    state_d          = state_q;
    bus.mem_valid    = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_wstrb    = '0;
    bus.d_rsp_valid  = 1'b0;
    bus.if_rsp_valid = 1'b0;
    bus.d_rdata      = '0;
    bus.if_rdata     = '0;
    bus.d_err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs_err) state_d = RESP;
        else if (d_hs || if_hs) state_d = ISSUE;
      end
      ISSUE: state_d = (LAT > 1) ? WAIT : RESP;
      WAIT: begin
        if (cnt_q == CNT_W'(LAT - 2)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are gated by rst so nothing leaks out in the cycle reset is applied.
    if (state_q == ISSUE && !rst) begin
      bus.mem_valid = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      if (we_q) begin
        bus.mem_wstrb = strb;
        bus.mem_wdata = wrep;
      end
    end

    if (state_q == RESP && !rst) begin
      bus.d_rsp_valid  = src_d_q;
      bus.if_rsp_valid = !src_d_q;
      bus.d_err        = src_d_q && err_q;
      if (!err_q) begin
        if (src_d_q) bus.d_rdata = rd_shift & rd_mask;
        else         bus.if_rdata = fetch_word;
      end
    end
  end
endmodule

// File: tb/tb_npc_mem_arb.sv
// tb/tb_npc_mem_arb.sv - scoreboard bench for npc_mem_arb at LAT=1 and LAT=3
`timescale 1ns/1ps
module tb_npc_mem_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int t0      = 0;

  bit          sel     = 1'b0;
  logic        d_valid = 1'b0;
  logic        i_valid = 1'b0;
  logic        d_we    = 1'b0;
  logic [1:0]  d_size  = 2'd0;
  logic [31:0] d_addr  = 32'h0;
  logic [31:0] i_addr  = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  npc_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  npc_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  assign b1.d_req_valid  = d_valid & ~sel;
  assign b3.d_req_valid  = d_valid & sel;
  assign b1.if_req_valid = i_valid & ~sel;
  assign b3.if_req_valid = i_valid & sel;
  assign b1.d_we = d_we;       assign b3.d_we = d_we;
  assign b1.d_size = d_size;   assign b3.d_size = d_size;
  assign b1.d_addr = d_addr;   assign b3.d_addr = d_addr;
  assign b1.if_addr = i_addr;  assign b3.if_addr = i_addr;
  assign b1.d_wdata = d_wdata; assign b3.d_wdata = d_wdata;
  assign b1.mem_rdata = m_rdata; assign b3.mem_rdata = m_rdata;

  npc_mem_arb #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  npc_mem_arb #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  logic        o_d_ready, o_i_ready, o_mem_valid, o_mem_we, o_d_rsp, o_i_rsp, o_d_err;
  logic [31:0] o_mem_addr, o_mem_wdata, o_d_rdata, o_i_rdata;
  logic [3:0]  o_mem_wstrb;
  assign o_d_ready   = sel ? b3.d_req_ready  : b1.d_req_ready;
  assign o_i_ready   = sel ? b3.if_req_ready : b1.if_req_ready;
  assign o_mem_valid = sel ? b3.mem_valid    : b1.mem_valid;
  assign o_mem_we    = sel ? b3.mem_we       : b1.mem_we;
  assign o_mem_addr  = sel ? b3.mem_addr     : b1.mem_addr;
  assign o_mem_wdata = sel ? b3.mem_wdata    : b1.mem_wdata;
  assign o_mem_wstrb = sel ? b3.mem_wstrb    : b1.mem_wstrb;
  assign o_d_rsp     = sel ? b3.d_rsp_valid  : b1.d_rsp_valid;
  assign o_i_rsp     = sel ? b3.if_rsp_valid : b1.if_rsp_valid;
  assign o_d_err     = sel ? b3.d_err        : b1.d_err;
  assign o_d_rdata   = sel ? b3.d_rdata      : b1.d_rdata;
  assign o_i_rdata   = sel ? b3.if_rdata     : b1.if_rdata;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        chk;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [31:0] rd, input logic chk, input logic err, input int at);
    exp_t e;
    e.is_d = is_d; e.rdata = rd; e.chk = chk; e.err = err; e.at = at;
    sb.push_back(e);
  endtask

  // Drives one data request in cycle 0, scrambles the fields in cycle 1, returns at negedge of cycle 1.
  task automatic send_d(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic chk, input logic err,
                        input int rsp_at);
    step();
    d_valid = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    t0 = cyc;
    push(1'b1, rd, chk, err, t0 + rsp_at);
    @(negedge clk);
    check({tag, ".d_ready"}, o_d_ready, 1);
    step();
    d_valid = 1'b0; d_we = ~we; d_size = 2'd0; d_addr = 32'h0BAD_0BAD; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag, input int bound);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (o_d_rsp || o_i_rsp) begin
        seen = 1'b1;
        check({tag, ".sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, ".src_is_data"}, o_d_rsp, e.is_d);
          check({tag, ".rsp_cycle"}, cyc - t0, e.at - t0);
          if (e.chk) check({tag, ".rdata"}, e.is_d ? o_d_rdata : o_i_rdata, e.rdata);
          check({tag, ".d_err"}, o_d_err, e.err);
        end
        break;
      end
      step();
      @(negedge clk);
    end
    check({tag, ".rsp_seen"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;

    // reset
    step();
    @(negedge clk);
    check("rst.u1_d_ready", b1.d_req_ready, 0);
    check("rst.u1_if_ready", b1.if_req_ready, 0);
    check("rst.u3_d_ready", b3.d_req_ready, 0);
    check("rst.u1_mem_valid", b1.mem_valid, 0);
    check("rst.u1_mem_addr", b1.mem_addr, 0);
    check("rst.u3_rsp", {b3.d_rsp_valid, b3.if_rsp_valid, b3.d_err}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst.rel_u1_ready", {b1.d_req_ready, b1.if_req_ready}, 2'b11);
    check("rst.rel_u3_ready", {b3.d_req_ready, b3.if_req_ready}, 2'b11);

    // LAT=1 load word
    sel = 1'b0;
    m_rdata = 32'hDEAD_BEEF;
    send_d("ldw", 1'b0, 2'd2, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2);
    check("ldw.mem_valid", o_mem_valid, 1);
    check("ldw.mem_addr", o_mem_addr, 32'h8000_0004);
    check("ldw.mem_we", o_mem_we, 0);
    check("ldw.ready_busy", o_d_ready, 0);
    wait_rsp("ldw", 6);
    step(); @(negedge clk);
    check("ldw.ready_back", {o_d_ready, o_i_ready}, 2'b11);
    check("ldw.ready_cycle", cyc - t0, 3);

    // store byte, replicated
    send_d("stb", 1'b1, 2'd0, 32'h8000_0003, 32'h1234_56A5, 32'h0, 1'b0, 1'b0, 2);
    check("stb.mem_we", o_mem_we, 1);
    check("stb.wstrb", o_mem_wstrb, 4'b1000);
    check("stb.wdata", o_mem_wdata, 32'hA5A5_A5A5);
    check("stb.mem_addr", o_mem_addr, 32'h8000_0000);
    wait_rsp("stb", 6);

    // store half, replicated
    send_d("sth", 1'b1, 2'd1, 32'h8000_0002, 32'hABCD_1234, 32'h0, 1'b0, 1'b0, 2);
    check("sth.wstrb", o_mem_wstrb, 4'b1100);
    check("sth.wdata", o_mem_wdata, 32'h1234_1234);
    wait_rsp("sth", 6);

    // fetch and byte load in the same cycle: data first
    step();
    m_rdata = 32'h1357_9BDF;
    d_valid = 1'b1; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h8000_0006;
    i_valid = 1'b1; i_addr = 32'h8000_0010;
    t0 = cyc;
    push(1'b1, 32'h0000_0057, 1'b1, 1'b0, t0 + 2);
    push(1'b0, 32'h1357_9BDF, 1'b1, 1'b0, t0 + 5);
    @(negedge clk);
    check("arb.if_ready_lost", o_i_ready, 0);
    check("arb.d_ready_won", o_d_ready, 1);
    step();
    d_valid = 1'b0;
    @(negedge clk);
    check("arb.ld_mem_addr", o_mem_addr, 32'h8000_0004);
    wait_rsp("arb.ld", 6);
    step(); @(negedge clk);
    check("arb.if_accept", o_i_ready, 1);
    check("arb.if_accept_cycle", cyc - t0, 3);
    step();
    i_valid = 1'b0;
    @(negedge clk);
    check("arb.if_mem_valid", o_mem_valid, 1);
    check("arb.if_mem_addr", o_mem_addr, 32'h8000_0010);
    wait_rsp("arb.if", 6);

    // misaligned word load
    m_rdata = 32'hCAFE_F00D;
`ifdef NPC_MEM_ARB_MISALIGN_CHK_EN
    send_d("mis", 1'b0, 2'd2, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    check("mis.no_mem_valid", o_mem_valid, 0);
    wait_rsp("mis", 6);
    step(); @(negedge clk);
    check("mis.ready_cycle2", o_d_ready, 1);
`else
    send_d("mis", 1'b0, 2'd2, 32'h8000_0001, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 2);
    check("mis.mem_valid", o_mem_valid, 1);
    check("mis.trunc_addr", o_mem_addr, 32'h8000_0000);
    wait_rsp("mis", 6);
    step(); @(negedge clk);
    check("mis.ready_back", o_d_ready, 1);
`endif

    // LAT=3 load half
    step();
    sel = 1'b1;
    m_rdata = 32'h1234_5678;
    send_d("l3", 1'b0, 2'd1, 32'h8000_0002, 32'h0, 32'h0000_1234, 1'b1, 1'b0, 4);
    check("l3.mem_valid", o_mem_valid, 1);
    check("l3.mem_addr", o_mem_addr, 32'h8000_0000);
    step(); @(negedge clk);
    check("l3.mem_valid_once", o_mem_valid, 0);
    check("l3.busy", o_d_ready, 0);
    wait_rsp("l3", 8);
    step(); @(negedge clk);
    check("l3.ready_back", o_d_ready, 1);
    check("l3.ready_cycle", cyc - t0, 5);

    // reset while in WAIT (LAT=3)
    send_d("rw", 1'b0, 2'd2, 32'h8000_0008, 32'h0, 32'h0, 1'b0, 1'b0, 4);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rw.ready_in_rst", {o_d_ready, o_i_ready}, 2'b00);
    check("rw.rsp_in_rst", {o_d_rsp, o_i_rsp}, 2'b00);
    step(); @(negedge clk);
    check("rw.ready_in_rst2", {o_d_ready, o_i_ready}, 2'b00);
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rw.ready_after", {o_d_ready, o_i_ready}, 2'b11);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_d_rsp || o_i_rsp || o_mem_valid) got = 1'b1;
      step(); @(negedge clk);
    end
    check("rw.no_rsp_after_rst", got, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
